// File: rtl/soc_vga_scanout.sv
// rtl/soc_vga_scanout.sv - 640x480 VGA scan-out with RGB332 expansion and 2x replication
module soc_vga_scanout #(
  parameter int CLK_DIV     = 4,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SCALE_SHIFT = 1,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] fb_base,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  input  logic [7:0]            fb_data,
  output logic [3:0]            vga_r,
  output logic [3:0]            vga_g,
  output logic [3:0]            vga_b,
  output logic                  vga_hs,
  output logic                  vga_vs,
  output logic                  vblank_irq
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FB_W    = H_ACTIVE >> SCALE_SHIFT;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int H_W   = $clog2(H_TOTAL + 1);
  localparam int V_W   = $clog2(V_TOTAL + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT      = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] H_SYNC_BEG = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] H_SYNC_END = H_W'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT      = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] V_SYNC_BEG = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] V_SYNC_END = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [V_W-1:0] V_MASK     = V_W'((1 << SCALE_SHIFT) - 1);

  localparam logic [ADDR_WIDTH-1:0] FB_STEP = ADDR_WIDTH'(FB_W);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  // Control decoded from the FSM: start latches the base, run_go lets the datapath advance
  logic start;
  logic run_go;

  logic [DIV_W-1:0]      div_q;
  logic [H_W-1:0]        h_cnt;
  logic [V_W-1:0]        v_cnt;
  logic [ADDR_WIDTH-1:0] line_base;
  // The first tick after enable only primes the fetch pipeline for pixel (0,0);
  // counters and outputs start moving from the second tick on.
  logic                  armed;

  logic                  tick;
  logic                  h_wrap;
  logic [H_W-1:0]        h_nxt;
  logic [V_W-1:0]        v_nxt;
  logic                  active;
  logic                  hs_pix;
  logic                  vs_pix;
  logic [3:0]            pix_r;
  logic [3:0]            pix_g;
  logic [3:0]            pix_b;

  // State register
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    run_go  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          start   = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (enable) begin
          run_go = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pixel-enable strobe, counter successors and per-pixel decode of the current position
  always_comb begin
    tick   = run_go && (div_q == DIV_LAST);
    h_wrap = (h_cnt == H_LAST);
    h_nxt  = h_wrap ? '0 : h_cnt + 1'b1;
    if (h_wrap) begin
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      v_nxt = v_cnt;
    end
    active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_pix = !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
    vs_pix = !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));
    pix_r  = {fb_data[7:5], fb_data[7]};
    pix_g  = {fb_data[4:2], fb_data[4]};
    pix_b  = {fb_data[1:0], fb_data[1:0]};
  end

  // Divider, raster counters, line addressing and the one-pixel output pipeline
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      div_q      <= '0;
      h_cnt      <= '0;
      v_cnt      <= '0;
      armed      <= 1'b0;
      line_base  <= '0;
      fb_addr    <= '0;
      vga_r      <= '0;
      vga_g      <= '0;
      vga_b      <= '0;
      vga_hs     <= 1'b1;
      vga_vs     <= 1'b1;
      vblank_irq <= 1'b0;
    end else if (!run_go) begin
      // Idle, or leaving RUN: drop everything so a restart begins at (0,0)
      div_q      <= '0;
      h_cnt      <= '0;
      v_cnt      <= '0;
      armed      <= 1'b0;
      fb_addr    <= '0;
      vga_r      <= '0;
      vga_g      <= '0;
      vga_b      <= '0;
      vga_hs     <= 1'b1;
      vga_vs     <= 1'b1;
      vblank_irq <= 1'b0;
      if (start) begin
        line_base <= fb_base;
      end
    end else begin
      div_q      <= tick ? '0 : div_q + 1'b1;
      vblank_irq <= 1'b0;

      // Address follows the counters one clock later; it freezes outside the active area
      if (armed && active) begin
        fb_addr <= line_base + ADDR_WIDTH'(h_cnt >> SCALE_SHIFT);
      end

      if (tick) begin
        if (!armed) begin
          armed <= 1'b1;
        end else begin
          h_cnt <= h_nxt;
          v_cnt <= v_nxt;

          // A new frame base is only picked up at the frame wrap; otherwise step one
          // framebuffer line every 2^SCALE_SHIFT display lines.
          if (h_wrap) begin
            if (v_nxt == '0) begin
              line_base <= fb_base;
            end else if ((v_nxt < V_ACT) && ((v_nxt & V_MASK) == '0)) begin
              line_base <= line_base + FB_STEP;
            end
          end

          // Register the pixel the counters pointed at until now; its data arrived meanwhile
          vga_r  <= active ? pix_r : 4'h0;
          vga_g  <= active ? pix_g : 4'h0;
          vga_b  <= active ? pix_b : 4'h0;
          vga_hs <= hs_pix;
          vga_vs <= vs_pix;

          vblank_irq <= h_wrap && (v_nxt == V_ACT);
        end
      end
    end
  end

endmodule

// File: tb/tb_soc_vga_scanout.sv
// tb/tb_soc_vga_scanout.sv - directed table-driven bench for soc_vga_scanout on a reduced raster
module tb_soc_vga_scanout;

  // Reduced raster: 16+2+3+3 = 24 pixels/line, 8+1+2+1 = 12 lines, FB_W = 8
  logic        clk;
  logic        res;
  logic        enable;
  logic [31:0] fb_base;
  logic [31:0] fb_addr;
  logic [7:0]  fb_data;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;
  logic        vblank_irq;

  int n_checks;
  int n_pass;
  int rel;

  soc_vga_scanout #(
    .CLK_DIV(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SCALE_SHIFT(1), .ADDR_WIDTH(32)
  ) dut (
    .clk(clk), .res(res), .enable(enable), .fb_base(fb_base),
    .fb_addr(fb_addr), .fb_data(fb_data),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vblank_irq(vblank_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Framebuffer port B model: one-clock read latency, data = low address byte
  always @(posedge clk) fb_data <= fb_addr[7:0];

  typedef struct {
    int          d;
    logic [31:0] addr;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        hs;
    logic        vs;
    logic        irq;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
  endtask

  task automatic goto(input int d);
    if (rel < d) begin
      while (rel < d) begin
        @(posedge clk);
        rel++;
      end
      #1;
    end
  endtask

  task automatic start_run();
    enable = 1'b1;
    @(posedge clk);
    rel = 0;
    #1;
  endtask

  task automatic check_idle(input string name, input int idx);
    check({name, "_addr"}, idx, fb_addr, 32'h0);
    check({name, "_rgb"}, idx, 32'({vga_r, vga_g, vga_b}), 32'h0);
    check({name, "_hs"}, idx, 32'(vga_hs), 32'h1);
    check({name, "_vs"}, idx, 32'(vga_vs), 32'h1);
    check({name, "_irq"}, idx, 32'(vblank_irq), 32'h0);
  endtask

  int n_irq;
  int t1;
  int t2;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rel      = 0;
    res      = 1'b0;
    enable   = 1'b0;
    fb_base  = 32'h10E3;

    // d = clocks after the edge that sees enable; tick 1 (prime) at d=4,
    // pixel p addressed over d=4p+5..4p+8, shown over d=4p+8..4p+11
    vecs[0]  = '{2,    32'h0,    4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{6,    32'h10E3, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{9,    32'h10E3, 4'hF, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{13,   32'h10E4, 4'hF, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{17,   32'h10E4, 4'hF, 4'h2, 4'h0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{69,   32'h10EA, 4'hF, 4'h4, 4'hA, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{73,   32'h10EA, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{79,   32'h10EA, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{80,   32'h10EA, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{89,   32'h10EA, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{93,   32'h10EA, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{105,  32'h10E3, 4'hF, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{198,  32'h10EB, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{201,  32'h10EB, 4'hF, 4'h4, 4'hF, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{678,  32'h10FB, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{681,  32'h10FB, 4'hF, 4'hD, 4'hF, 1'b1, 1'b1, 1'b0};
    vecs[16] = '{771,  32'h1102, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0};
    vecs[17] = '{772,  32'h1102, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1};
    vecs[18] = '{773,  32'h1102, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0};
    vecs[19] = '{873,  32'h1102, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0};
    vecs[20] = '{1041, 32'h1102, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[21] = '{1065, 32'h1102, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0};
    vecs[22] = '{1158, 32'h10E3, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0};
    vecs[23] = '{1161, 32'h10E3, 4'hF, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check_idle("reset", 0);
    res = 1'b1;
    start_run();

    for (int i = 0; i < NV; i++) begin
      goto(vecs[i].d);
      check("addr", i, fb_addr, vecs[i].addr);
      check("r", i, 32'(vga_r), 32'(vecs[i].r));
      check("g", i, 32'(vga_g), 32'(vecs[i].g));
      check("b", i, 32'(vga_b), 32'(vecs[i].b));
      check("hs", i, 32'(vga_hs), 32'(vecs[i].hs));
      check("vs", i, 32'(vga_vs), 32'(vecs[i].vs));
      check("irq", i, 32'(vblank_irq), 32'(vecs[i].irq));
    end

    // vblank_irq over the next two frames: single-clock pulses 1152 clocks apart
    n_irq = 0;
    t1 = 0;
    t2 = 0;
    while (rel < 3200) begin
      @(posedge clk);
      rel++;
      #1;
      if (vblank_irq === 1'b1) begin
        n_irq++;
        if (n_irq == 1) t1 = rel;
        else if (n_irq == 2) t2 = rel;
      end
    end
    check("irq_count", 0, 32'(n_irq), 32'd2);
    check("irq_first", 0, 32'(t1), 32'd1924);
    check("irq_period", 0, 32'(t2 - t1), 32'd1152);

    // Disable mid-frame at (h=3, v=2) of frame 3, then restart from (0,0)
    goto(3665);
    check("pre_dis_addr", 0, fb_addr, 32'h10EC);
    check("pre_dis_rgb", 0, 32'({vga_r, vga_g, vga_b}), 32'h F60);
    enable = 1'b0;
    goto(3666);
    check_idle("dis", 0);
    goto(3670);
    check_idle("dis", 1);
    start_run();
    goto(6);
    check("re_addr", 0, fb_addr, 32'h10E3);
    goto(9);
    check("re_rgb", 0, 32'({vga_r, vga_g, vga_b}), 32'hF0F);
    goto(80);
    check("re_hs", 0, 32'(vga_hs), 32'h0);

    // Double buffer: base moves mid-frame, takes effect only at the frame wrap
    enable  = 1'b0;
    fb_base = 32'h0;
    @(posedge clk);
    #1;
    start_run();
    goto(390);
    fb_base = 32'h20000;
    goto(582);
    check("db_line6", 0, fb_addr, 32'h18);
    goto(738);
    check("db_last", 0, fb_addr, 32'h1F);
    goto(1158);
    check("db_next", 0, fb_addr, 32'h20000);
    goto(1166);
    check("db_next", 1, fb_addr, 32'h20001);
    goto(1233);
    check("pre_rst_addr", 0, fb_addr, 32'h20007);
    check("pre_rst_hs", 0, 32'(vga_hs), 32'h0);

    // Asynchronous reset between clock edges
    #3;
    res = 1'b0;
    #1;
    check_idle("async_rst", 0);
    repeat (2) @(posedge clk);
    #1;
    check_idle("async_rst", 1);
    res = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
